seq_signed_or_unsigned_mul: RTL and testbench
=============================================

# seq_signed_or_unsigned_mul

Iterative, parameterised n×n multiplier producing a 2n-bit result, either signed (two's complement) or unsigned, selected per operation. It uses one shift-add step per clock. Operands enter through a valid/ready handshake, and the result leaves through a second valid/ready handshake with full backpressure. It is the area-lean, sequential successor to the combinational signed/unsigned multipliers, for pipelines where one product per ~n cycles is enough.

## Interface
- n, default 8, operand width in bits; legal range n ≥ 2
- clk  input  1  clock; all state changes on rising edge
- rst_n  input  1  asynchronous, active-low reset
- up_valid  input  1  operands a, b, signed_mul are valid this cycle
- up_ready  output  1  block can accept operands (high only in IDLE)
- a  input  n  multiplicand
- b  input  n  multiplier
- signed_mul  input  1  1 = treat a, b, res as two's complement; 0 = unsigned
- down_valid  output  1  res holds a completed product
- down_ready  input  1  consumer accepts res this cycle
- res  output  2n  product

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: up_ready = 1, down_valid = 0.
  - On up_valid && up_ready, capture a, b and signed_mul into internal registers.
  - Load the step counter with n and go to BUSY.
- Sign preprocessing at capture, applied only when signed_mul = 1:
  - Store |a| and |b| as n-bit unsigned magnitudes.
  - Store neg = a[n-1] ^ b[n-1].
  - |−2^(n−1)| = 2^(n−1) fits in n bits unsigned.
  - When signed_mul = 0, magnitudes are the raw operands and neg = 0.
- BUSY: up_ready = 0, down_valid = 0. Each cycle:
  - If the multiplier LSB is 1, add the shifted multiplicand into the 2n-bit accumulator.
  - Shift the multiplier right by 1 and the multiplicand left by 1 (or use an equivalent right-shifting accumulator).
  - Decrement the counter.
  - After the n-th step, go to DONE and register res = neg ? −acc : acc (2n-bit two's-complement negation).
- DONE: down_valid = 1, up_ready = 0, res held stable.
  - On down_ready = 1, go to IDLE.
  - While down_ready = 0, stay in DONE; res and down_valid are unchanged.
- Width rules:
  - All internal arithmetic is 2n bits; no overflow is possible in either mode.
  - Signed extreme: (−2^(n−1))² = 2^(2n−2), which is representable.
- The result must equal the combinational reference exactly:
  - Unsigned: a*b zero-extended.
  - Signed: $signed(a)*$signed(b) as 2n bits.
- Inputs a, b and signed_mul are ignored outside the accepting cycle. Changing them during BUSY or DONE has no effect.
- up_valid while not in IDLE is ignored. The upstream must hold its request until up_ready.

## Timing
- Reset (rst_n low, asynchronous):
  - State = IDLE, counter = 0, accumulator = 0, res = 0.
  - down_valid = 0, up_ready = 1 (combinational from state).
- Outputs are registered or decoded purely from the state register; there are no combinational input→output paths.
- Latency: operands accepted on rising edge E. down_valid rises after edge E+n and is first sampled high in the cycle following E+n.
- Throughput: with down_ready held at 1, the sequence is accept, n BUSY cycles, 1 DONE cycle, 1 IDLE cycle. That gives one product every n+2 cycles.
- Transfer from DONE happens on the edge where down_ready = 1. The next IDLE cycle can accept new operands immediately.
- Reset asserted mid-BUSY or mid-DONE:
  - Return to IDLE immediately and discard the in-flight product.
  - down_valid drops asynchronously.
  - No spurious down_valid after release.
- First edge after rst_n deasserts: the block may accept operands if up_valid = 1.

## Test plan
- n=8, unsigned: a=0xFF, b=0xFF, signed_mul=0, down_ready=1 → down_valid after exactly 8 edges, res=0xFE01; down_valid lasts 1 cycle; up_ready returns 1 the next cycle.
- n=8, same bits in both modes:
  - a=0xFF, b=0x01, signed_mul=1 → res=0xFFFF (−1).
  - Same operands, signed_mul=0 → res=0x00FF.
  - a=0x80, b=0x80, signed_mul=1 → res=0x4000.
  - a=0x80, b=0x7F, signed_mul=1 → res=0xC080 (−16256).
- Backpressure: hold down_ready=0 for 5 cycles after down_valid, toggling a/b/up_valid meanwhile → res, down_valid stable; up_ready=0 throughout; no new accept until after the down handshake.
- Reset mid-operation: assert rst_n=0 on cycle 3 of BUSY → down_valid=0, res=0, up_ready=1 immediately; a fresh operation after release yields the correct product with normal latency.
- Zero and one:
  - a=0, b=0x80, signed_mul=1 → res=0x0000.
  - a=0x01, b=0x80, signed_mul=1 → res=0xFF80.
- Random back-to-back, n=4, 8 and 13: ≥10k operations with random signed_mul, random up_valid/down_ready gaps, compared against a $signed/unsigned golden model → zero mismatches; every product delivered exactly once, in order.

Source files
------------

// File: rtl/seq_signed_or_unsigned_mul.sv
// Sequential shift-add multiplier, n x n -> 2n bits, signed or unsigned per operation.
// Signed operands are turned into magnitudes when they are captured. The
// magnitudes are multiplied unsigned, one shift-add step per clock. The sign
// is reapplied by a single 2n-bit negation as the result is registered.
module seq_signed_or_unsigned_mul #(
   parameter int n = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           up_valid,
   output logic           up_ready,
   input  logic [n-1:0]   a,
   input  logic [n-1:0]   b,
   input  logic           signed_mul,
   output logic           down_valid,
   input  logic           down_ready,
   output logic [2*n-1:0] res
);

   localparam int CW = $clog2(n + 1);
   localparam logic [CW-1:0]  CNT_N   = CW'(n);
   localparam logic [CW-1:0]  CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [n-1:0]   ONE_N   = {{(n-1){1'b0}}, 1'b1};
   localparam logic [2*n-1:0] ONE_2N  = {{(2*n-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q;
   logic [CW-1:0]  cnt_q;
   logic [2*n-1:0] mcand_q;
   logic [n-1:0]   mplier_q;
   logic [2*n-1:0] acc_q;
   logic           neg_q;
   logic [2*n-1:0] res_q;

   logic [n-1:0]   mag_a_d;
   logic [n-1:0]   mag_b_d;
   logic           neg_d;
   logic [2*n-1:0] acc_d;
   logic [2*n-1:0] res_d;

   // Capture-time sign stripping. The magnitude of the most negative value
   // fits in n unsigned bits, so no extra width is needed.
   always_comb begin
      mag_a_d = a;
      mag_b_d = b;
      neg_d   = 1'b0;
      if (signed_mul) begin
         if (a[n-1]) mag_a_d = ~a + ONE_N;
         if (b[n-1]) mag_b_d = ~b + ONE_N;
         neg_d = a[n-1] ^ b[n-1];
      end
   end

   // One shift-add step, plus the sign-corrected result for the final step.
   always_comb begin
      acc_d = acc_q;
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      res_d = neg_q ? (~acc_d + ONE_2N) : acc_d;
   end

   // Control FSM and datapath registers. Reset returns to IDLE at once and
   // discards any product still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         res_q    <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (up_valid) begin
                  mcand_q  <= {{n{1'b0}}, mag_a_d};
                  mplier_q <= mag_b_d;
                  neg_q    <= neg_d;
                  acc_q    <= '0;
                  cnt_q    <= CNT_N;
                  state_q  <= S_BUSY;
               end
            end
            S_BUSY: begin
               acc_q    <= acc_d;
               mcand_q  <= {mcand_q[2*n-2:0], 1'b0};
               mplier_q <= {1'b0, mplier_q[n-1:1]};
               cnt_q    <= cnt_q - CNT_ONE;
               if (cnt_q == CNT_ONE) begin
                  res_q   <= res_d;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               if (down_ready) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Handshake outputs are decoded from the state register only.
   assign up_ready   = (state_q == S_IDLE);
   assign down_valid = (state_q == S_DONE);
   assign res        = res_q;

endmodule

// File: tb/tb_seq_signed_or_unsigned_mul.sv
// Self-checking bench: directed corner cases plus randomized back-to-back traffic
// scored against an integer-arithmetic reference model.
module tb_seq_signed_or_unsigned_mul;

   localparam int N    = 8;
   localparam int W    = 2 * N;
   localparam int NOPS = 2000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         up_valid = 1'b0;
   logic         up_ready;
   logic [N-1:0] a = '0;
   logic [N-1:0] b = '0;
   logic         signed_mul = 1'b0;
   logic         down_valid;
   logic         down_ready = 1'b0;
   logic [W-1:0] res;

   int n_checks = 0;
   int n_fails  = 0;

   logic [W-1:0] exp_q[$];

   seq_signed_or_unsigned_mul #(.n(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid   (up_valid),
      .up_ready   (up_ready),
      .a          (a),
      .b          (b),
      .signed_mul (signed_mul),
      .down_valid (down_valid),
      .down_ready (down_ready),
      .res        (res)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference product: interpret operands as integers, multiply, keep 2n bits.
   function automatic logic [W-1:0] ref_mul(input logic [N-1:0] x, input logic [N-1:0] y, input bit sm);
      longint xi, yi, p;
      xi = longint'(x);
      yi = longint'(y);
      if (sm && xi >= (longint'(1) << (N - 1))) xi = xi - (longint'(1) << N);
      if (sm && yi >= (longint'(1) << (N - 1))) yi = yi - (longint'(1) << N);
      p = xi * yi;
      return W'(p);
   endfunction

   // One operation with down_ready held high; returns result and accept-to-valid edge count.
   task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input bit sm,
                        output logic [W-1:0] r, output int lat);
      @(negedge clk);
      a = ta; b = tb_v; signed_mul = sm; up_valid = 1'b1; down_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      up_valid = 1'b0;
      lat = 0;
      while (!down_valid && lat < 100) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      r = res;
      $display("op a=0x%0h b=0x%0h signed=%0d -> res=0x%0h latency=%0d", ta, tb_v, sm, r, lat);
   endtask

   task automatic directed(input logic [N-1:0] ta, input logic [N-1:0] tb_v, input bit sm,
                           input logic [W-1:0] exp, input string tag);
      logic [W-1:0] r;
      int lat;
      do_op(ta, tb_v, sm, r, lat);
      check({tag, "_res"}, 64'(r), 64'(exp));
      check({tag, "_lat"}, 64'(lat), 64'(N));
      @(posedge clk);
      @(negedge clk);
      check({tag, "_dv_drop"}, 64'(down_valid), 64'd0);
      check({tag, "_ur_back"}, 64'(up_ready), 64'd1);
   endtask

   initial begin
      logic [W-1:0] held;
      logic [W-1:0] r;
      int lat;

      // Reset state
      #12;
      check("rst_up_ready", 64'(up_ready), 64'd1);
      check("rst_down_valid", 64'(down_valid), 64'd0);
      check("rst_res", 64'(res), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed products
      directed(8'hFF, 8'hFF, 1'b0, 16'hFE01, "uns_ff_ff");
      directed(8'hFF, 8'h01, 1'b1, 16'hFFFF, "sgn_m1_1");
      directed(8'hFF, 8'h01, 1'b0, 16'h00FF, "uns_ff_1");
      directed(8'h80, 8'h80, 1'b1, 16'h4000, "sgn_min_min");
      directed(8'h80, 8'h7F, 1'b1, 16'hC080, "sgn_min_max");
      directed(8'h00, 8'h80, 1'b1, 16'h0000, "sgn_zero");
      directed(8'h01, 8'h80, 1'b1, 16'hFF80, "sgn_one_min");

      // Backpressure: result must hold while downstream stalls
      @(negedge clk);
      a = 8'h93; b = 8'hC5; signed_mul = 1'b1; up_valid = 1'b1; down_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      up_valid = 1'b0;
      for (int i = 0; i < 100 && !down_valid; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("bp_valid", 64'(down_valid), 64'd1);
      held = res;
      check("bp_res", 64'(held), 64'(ref_mul(8'h93, 8'hC5, 1'b1)));
      for (int i = 0; i < 5; i++) begin
         a = N'($urandom); b = N'($urandom); signed_mul = 1'($urandom); up_valid = 1'($urandom);
         @(posedge clk);
         @(negedge clk);
         check("bp_hold_valid", 64'(down_valid), 64'd1);
         check("bp_hold_res", 64'(res), 64'(held));
         check("bp_up_ready", 64'(up_ready), 64'd0);
      end
      up_valid = 1'b0;
      down_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_release_dv", 64'(down_valid), 64'd0);
      check("bp_release_ur", 64'(up_ready), 64'd1);
      $display("backpressure held res=0x%0h for 5 cycles", held);

      // Reset during the third BUSY cycle
      a = 8'h37; b = 8'h5A; signed_mul = 1'b0; up_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      up_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      @(posedge clk); @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_dv", 64'(down_valid), 64'd0);
      check("midrst_res", 64'(res), 64'd0);
      check("midrst_ur", 64'(up_ready), 64'd1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("postrst_no_dv", 64'(down_valid), 64'd0);
      end
      do_op(8'hA7, 8'h3C, 1'b1, r, lat);
      check("postrst_res", 64'(r), 64'(ref_mul(8'hA7, 8'h3C, 1'b1)));
      check("postrst_lat", 64'(lat), 64'(N));
      @(posedge clk);
      @(negedge clk);

      // Randomized back-to-back traffic
      down_ready = 1'b0;
      fork
         begin : producer
            for (int i = 0; i < NOPS; i++) begin
               logic [N-1:0] xa, xb;
               bit xs, hs;
               int t;
               int gap;
               gap = $urandom_range(0, 3);
               for (int g = 0; g < gap; g++) begin
                  up_valid = 1'b0;
                  a = N'($urandom); b = N'($urandom); signed_mul = 1'($urandom);
                  @(posedge clk);
                  @(negedge clk);
               end
               xa = N'($urandom); xb = N'($urandom); xs = 1'($urandom);
               a = xa; b = xb; signed_mul = xs; up_valid = 1'b1;
               hs = 1'b0;
               t = 0;
               while (!hs && t <= 200) begin
                  hs = up_ready;
                  @(posedge clk);
                  @(negedge clk);
                  t++;
               end
               if (!hs) begin
                  check("rand_accept_timeout", 64'd0, 64'd1);
                  break;
               end
               exp_q.push_back(ref_mul(xa, xb, xs));
               up_valid = 1'b0;
               a = N'($urandom); b = N'($urandom); signed_mul = 1'($urandom);
            end
            up_valid = 1'b0;
         end
         begin : consumer
            int recv;
            int cyc;
            bit stalled;
            logic [W-1:0] stall_res;
            logic [W-1:0] e;
            recv = 0;
            cyc = 0;
            stalled = 1'b0;
            stall_res = '0;
            while (recv < NOPS && cyc < 90000) begin
               @(negedge clk);
               cyc++;
               if (stalled) begin
                  check("rand_stall_valid", 64'(down_valid), 64'd1);
                  check("rand_stall_res", 64'(res), 64'(stall_res));
               end
               down_ready = ($urandom_range(0, 9) < 7);
               stalled = down_valid && !down_ready;
               stall_res = res;
               if (down_valid && down_ready) begin
                  if (exp_q.size() == 0) begin
                     check("rand_spurious", 64'd1, 64'd0);
                  end else begin
                     e = exp_q.pop_front();
                     check("rand_res", 64'(res), 64'(e));
                     $display("rand op %0d res=0x%0h expected=0x%0h", recv, res, e);
                  end
                  recv++;
               end
            end
            if (recv < NOPS) check("rand_recv_timeout", 64'(recv), 64'(NOPS));
            down_ready = 1'b0;
         end
      join
      check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
